// File: rtl/answer_entry.sv
// Answer entry: synchronized and debounced buttons, switch capture, compare against target, score keeping.
// Optional build macro SCORE_SATURATE_EN: score holds at 9 instead of wrapping to 0.
module answer_entry #(
    parameter int unsigned DEBOUNCE_CYCLES = 1000000
) (
    input  logic       clk_in,
    input  logic       reset,
    input  logic [9:0] sw,
    input  logic       btn_submit,
    input  logic       btn_clear,
    input  logic [9:0] target,
    output logic [9:0] binary,
    output logic [3:0] score,
    output logic       result_valid,
    output logic       correct
);

    localparam int          BTN_SUBMIT = 0;
    localparam int          BTN_CLEAR  = 1;
    localparam logic [23:0] CNT_LAST   = 24'(DEBOUNCE_CYCLES - 32'd1);

    typedef enum logic [1:0] {
        IDLE         = 2'd0,
        CHECK        = 2'd1,
        RESULT       = 2'd2,
        WAIT_RELEASE = 2'd3
    } state_t;

    logic [9:0]  sw_meta_r;
    logic [9:0]  sw_sync_r;
    logic [1:0]  btn_raw_s;
    logic [1:0]  btn_meta_r;
    logic [1:0]  btn_sync_r;
    logic [1:0]  btn_acc_r;
    logic [1:0]  btn_acc_d_r;
    logic [23:0] btn_cnt_r [2];
    logic [1:0]  press_s;

    state_t      state_r;
    logic [9:0]  binary_r;
    logic [3:0]  score_r;
    logic        result_valid_r;
    logic        correct_r;

    // Score after one more correct answer; 9 is the top of the displayable range.
    function automatic logic [3:0] score_next(input logic [3:0] cur);
        logic [3:0] nxt;
        if (cur >= 4'd9) begin
`ifdef SCORE_SATURATE_EN
            nxt = 4'd9;
`else
            nxt = 4'd0;
`endif
        end else begin
            nxt = cur + 4'd1;
        end
        return nxt;
    endfunction

    assign btn_raw_s = {btn_clear, btn_submit};
    assign press_s   = btn_acc_r & ~btn_acc_d_r;

    // Two-flop synchronizers for the switches and both raw buttons.
    always_ff @(posedge clk_in or negedge reset) begin
        if (!reset) begin
            sw_meta_r  <= 10'd0;
            sw_sync_r  <= 10'd0;
            btn_meta_r <= 2'b00;
            btn_sync_r <= 2'b00;
        end else begin
            sw_meta_r  <= sw;
            sw_sync_r  <= sw_meta_r;
            btn_meta_r <= btn_raw_s;
            btn_sync_r <= btn_meta_r;
        end
    end

    // Debouncers: a level is accepted only after it has differed from the accepted level for DEBOUNCE_CYCLES cycles.
    always_ff @(posedge clk_in or negedge reset) begin
        if (!reset) begin
            btn_acc_r    <= 2'b00;
            btn_acc_d_r  <= 2'b00;
            btn_cnt_r[0] <= 24'd0;
            btn_cnt_r[1] <= 24'd0;
        end else begin
            btn_acc_d_r <= btn_acc_r;
            for (int i = 0; i < 2; i++) begin
                if (btn_sync_r[i] == btn_acc_r[i]) begin
                    btn_cnt_r[i] <= 24'd0;
                end else if (btn_cnt_r[i] == CNT_LAST) begin
                    btn_acc_r[i] <= btn_sync_r[i];
                    btn_cnt_r[i] <= 24'd0;
                end else begin
                    btn_cnt_r[i] <= btn_cnt_r[i] + 24'd1;
                end
            end
        end
    end

    // Control FSM with registered entry, result and score outputs.
    always_ff @(posedge clk_in or negedge reset) begin
        if (!reset) begin
            state_r        <= IDLE;
            binary_r       <= 10'd0;
            score_r        <= 4'd0;
            result_valid_r <= 1'b0;
            correct_r      <= 1'b0;
        end else begin
            result_valid_r <= 1'b0;
            case (state_r)
                IDLE: begin
                    binary_r <= sw_sync_r;
                    if (press_s[BTN_SUBMIT]) begin
                        state_r <= CHECK;
                    end else begin
                        state_r <= IDLE;
                    end
                end
                CHECK: begin
                    correct_r      <= (binary_r == target);
                    result_valid_r <= 1'b1;
                    state_r        <= RESULT;
                end
                RESULT: begin
                    state_r <= WAIT_RELEASE;
                end
                WAIT_RELEASE: begin
                    if (!btn_acc_r[BTN_SUBMIT]) begin
                        state_r <= IDLE;
                    end else begin
                        state_r <= WAIT_RELEASE;
                    end
                end
                default: begin
                    state_r <= IDLE;
                end
            endcase

            // Clear overrides a simultaneous increment.
            if (press_s[BTN_CLEAR]) begin
                score_r <= 4'd0;
            end else if ((state_r == RESULT) && correct_r) begin
                score_r <= score_next(score_r);
            end else begin
                score_r <= score_r;
            end
        end
    end

    assign binary       = binary_r;
    assign score        = score_r;
    assign result_valid = result_valid_r;
    assign correct      = correct_r;

endmodule

// File: tb/tb_answer_entry.sv
// Scoreboard bench for answer_entry with DEBOUNCE_CYCLES=4; expected results queued at submit, checked on result_valid.
module tb_answer_entry;

    logic       clk_in = 1'b0;
    logic       reset;
    logic [9:0] sw;
    logic       btn_submit;
    logic       btn_clear;
    logic [9:0] target;
    logic [9:0] binary;
    logic [3:0] score;
    logic       result_valid;
    logic       correct;

    typedef struct packed {
        logic       c;
        logic [9:0] b;
    } exp_t;

    exp_t sb_q[$];
    int   n_checks  = 0;
    int   n_errors  = 0;
    int   rv_count  = 0;
    int   exp_score = 0;

    answer_entry #(.DEBOUNCE_CYCLES(4)) dut (
        .clk_in      (clk_in),
        .reset       (reset),
        .sw          (sw),
        .btn_submit  (btn_submit),
        .btn_clear   (btn_clear),
        .target      (target),
        .binary      (binary),
        .score       (score),
        .result_valid(result_valid),
        .correct     (correct)
    );

    always #5 clk_in = ~clk_in;

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    function automatic int model_inc(input int cur);
`ifdef SCORE_SATURATE_EN
        return (cur >= 9) ? 9 : cur + 1;
`else
        return (cur >= 9) ? 0 : cur + 1;
`endif
    endfunction

    // Scoreboard monitor: every result pulse must match the oldest queued expectation.
    always @(negedge clk_in) begin
        if (reset && result_valid) begin
            rv_count++;
            if (sb_q.size() == 0) begin
                check_val("unexpected_result_valid", 32'd1, 32'd0);
            end else begin
                exp_t e;
                e = sb_q.pop_front();
                check_val("correct", 32'(correct), 32'(e.c));
                check_val("binary_at_result", 32'(binary), 32'(e.b));
            end
        end
    end

    // clr_mode: 0 none, 1 clear together with submit, 2 clear timed to land on the RESULT cycle.
    task automatic do_submit(input logic [9:0] s, input logic [9:0] t, input logic [9:0] sw_late,
                             input int clr_mode, input int hold);
        int   lat;
        int   rv_before;
        logic seen;
        logic exp_c;
        sw     = s;
        target = t;
        repeat (5) @(posedge clk_in);
        exp_c = (s == t);
        sb_q.push_back({exp_c, s});
        rv_before = rv_count;
        @(posedge clk_in);
        #1;
        btn_submit = 1'b1;
        if (clr_mode == 1) btn_clear = 1'b1;
        lat  = 0;
        seen = 1'b0;
        while (!seen && lat < 40) begin
            @(posedge clk_in);
            lat++;
            if (clr_mode == 2 && lat == 2) begin
                #1;
                btn_clear = 1'b1;
            end
            @(negedge clk_in);
            if (result_valid) seen = 1'b1;
        end
        if (seen) begin
            check_val("latency", 32'(lat), 32'd8);
        end else begin
            check_val("result_timeout", 32'd0, 32'd1);
            if (sb_q.size() > 0) void'(sb_q.pop_back());
        end
        if (clr_mode == 1) exp_score = 0;
        if (exp_c) exp_score = model_inc(exp_score);
        if (clr_mode == 2) exp_score = 0;
        sw = sw_late;
        repeat (hold) @(posedge clk_in);
        @(negedge clk_in);
        check_val("binary_frozen", 32'(binary), 32'(s));
        @(posedge clk_in);
        #1;
        btn_submit = 1'b0;
        btn_clear  = 1'b0;
        repeat (14) @(posedge clk_in);
        @(negedge clk_in);
        check_val("score", 32'(score), 32'(exp_score));
        check_val("correct_held", 32'(correct), 32'(exp_c));
        check_val("binary_after_release", 32'(binary), 32'(sw_late));
        check_val("pulse_count", 32'(rv_count - rv_before), 32'd1);
    endtask

    initial begin
        int rv_before;
        reset      = 1'b0;
        sw         = 10'd0;
        btn_submit = 1'b0;
        btn_clear  = 1'b0;
        target     = 10'd0;
        repeat (3) @(posedge clk_in);
        #1;
        reset = 1'b1;
        @(negedge clk_in);
        check_val("reset_binary", 32'(binary), 32'd0);
        check_val("reset_score", 32'(score), 32'd0);
        check_val("reset_result_valid", 32'(result_valid), 32'd0);
        check_val("reset_correct", 32'(correct), 32'd0);

        // Correct answer, held well past the result.
        do_submit(10'd37, 10'd37, 10'd37, 0, 4);
        // Wrong answer; switches move while waiting for release.
        do_submit(10'd500, 10'd499, 10'd12, 0, 3);

        // Bouncing submit: toggles every 2 cycles for 20 cycles, then held high.
        sw     = 10'd5;
        target = 10'd5;
        repeat (5) @(posedge clk_in);
        sb_q.push_back({1'b1, 10'd5});
        rv_before = rv_count;
        for (int i = 0; i < 10; i++) begin
            @(posedge clk_in);
            #1;
            btn_submit = ~btn_submit;
            @(posedge clk_in);
        end
        #1;
        btn_submit = 1'b1;
        repeat (30) @(posedge clk_in);
        #1;
        btn_submit = 1'b0;
        repeat (14) @(posedge clk_in);
        @(negedge clk_in);
        exp_score = model_inc(exp_score);
        check_val("bounce_pulse_count", 32'(rv_count - rv_before), 32'd1);
        check_val("bounce_score", 32'(score), 32'(exp_score));

        // Reach score 3, then clear alone.
        do_submit(10'd1, 10'd1, 10'd1, 0, 1);
        check_val("score_three", 32'(score), 32'd3);
        @(posedge clk_in);
        #1;
        btn_clear = 1'b1;
        repeat (10) @(posedge clk_in);
        #1;
        btn_clear = 1'b0;
        repeat (10) @(posedge clk_in);
        @(negedge clk_in);
        exp_score = 0;
        check_val("clear_alone", 32'(score), 32'd0);

        // Reach 5, then clear colliding with a correct RESULT cycle.
        for (int i = 0; i < 5; i++) do_submit(10'(i + 100), 10'(i + 100), 10'(i + 100), 0, 1);
        check_val("score_five", 32'(score), 32'd5);
        do_submit(10'd700, 10'd700, 10'd700, 2, 1);

        // Reach 4, then reset during CHECK.
        for (int i = 0; i < 4; i++) do_submit(10'(i + 200), 10'(i + 200), 10'(i + 200), 0, 1);
        check_val("score_four", 32'(score), 32'd4);
        sw     = 10'd300;
        target = 10'd300;
        repeat (5) @(posedge clk_in);
        rv_before = rv_count;
        @(posedge clk_in);
        #1;
        btn_submit = 1'b1;
        repeat (7) @(posedge clk_in);
        #2;
        reset      = 1'b0;
        btn_submit = 1'b0;
        #1;
        check_val("midreset_binary", 32'(binary), 32'd0);
        check_val("midreset_score", 32'(score), 32'd0);
        check_val("midreset_result_valid", 32'(result_valid), 32'd0);
        check_val("midreset_correct", 32'(correct), 32'd0);
        repeat (2) @(posedge clk_in);
        #1;
        reset     = 1'b1;
        exp_score = 0;
        repeat (20) @(posedge clk_in);
        @(negedge clk_in);
        check_val("midreset_no_result", 32'(rv_count - rv_before), 32'd0);

        // Nine correct answers, then the tenth exercises saturate or wrap.
        for (int i = 0; i < 9; i++) do_submit(10'(i * 97), 10'(i * 97), 10'(i * 97), 0, 1);
        check_val("score_nine", 32'(score), 32'd9);
        do_submit(10'd1023, 10'd1023, 10'd1023, 0, 1);
`ifdef SCORE_SATURATE_EN
        check_val("tenth_score", 32'(score), 32'd9);
`else
        check_val("tenth_score", 32'(score), 32'd0);
`endif

        // Submit and clear together in IDLE: clear, then the correct result counts.
        do_submit(10'd64, 10'd64, 10'd64, 1, 1);
        check_val("simul_score", 32'(score), 32'd1);

        check_val("scoreboard_empty", 32'(sb_q.size()), 32'd0);
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/answer_entry.md
ANSWER_ENTRY -- requirements
Module: answer_entry

Interface
- REQ-001: DEBOUNCE_CYCLES, default 1000000, number of consecutive stable clk_in cycles before a button level is accepted (legal range 2..2^24).
- REQ-002: clk_in  input  1  single system clock, all logic rising-edge.
- REQ-003: reset  input  1  asynchronous, active-low reset.
- REQ-004: sw  input  10  raw user switch value, asynchronous to clk_in.
- REQ-005: btn_submit  input  1  raw submit push-button, active-high, bouncing.
- REQ-006: btn_clear  input  1  raw score-clear push-button, active-high, bouncing.
- REQ-007: target  input  10  expected answer, stable while FSM is outside IDLE.
- REQ-008: binary  output  10  registered user entry, fed to the display block.
- REQ-009: score  output  4  registered correct-answer count, 0..9, fed to the display block.
- REQ-010: result_valid  output  1  one-cycle pulse marking a completed comparison.
- REQ-011: correct  output  1  comparison result, valid while result_valid is high, held until next result.

Function
- REQ-012: sw, btn_submit, btn_clear each pass through a 2-flop synchronizer before any use.
- REQ-013: Each button has its own debouncer: counter resets on any change of synchronized level vs. accepted level; accepted level updates when counter reaches DEBOUNCE_CYCLES-1 with level unchanged.
- REQ-014: Rising edge of an accepted button level produces a one-cycle internal press pulse; falling edges produce nothing.
- REQ-015: FSM states IDLE, CHECK, RESULT, WAIT_RELEASE.
- REQ-016: IDLE: binary loads synchronized sw every cycle; submit press -> CHECK.
- REQ-017: CHECK (1 cycle): binary frozen; compare binary == target (unsigned, full 10 bits) into registered result -> RESULT.
- REQ-018: RESULT (1 cycle): result_valid=1, correct=compare result; if correct, score increments -> WAIT_RELEASE.
- REQ-019: WAIT_RELEASE: binary frozen; accepted submit level low -> IDLE; further submit presses impossible until release.
- REQ-020: Latency: result_valid asserts exactly 2 cycles after the submit press pulse.
- REQ-021: Clear press sets score to 0 in any state, does not change FSM state or binary.
- REQ-022: Clear press coinciding with a RESULT-cycle increment: clear wins, score=0.
- REQ-023: Submit and clear presses in the same cycle in IDLE: both act (FSM -> CHECK, score -> 0).
- REQ-024: No other event changes score; score never exceeds 9.

Reset
- REQ-025: reset low asynchronously forces: FSM IDLE, binary=0, score=0, result_valid=0, correct=0, synchronizers=0, debounce counters=0, accepted levels=0.
- REQ-026: Reset asserted mid-comparison discards it; no result_valid pulse follows deassertion.
- REQ-027: A button held high through reset deassertion is accepted after DEBOUNCE_CYCLES and counts as one press.

Configuration
- REQ-028: Macro SCORE_SATURATE_EN defined: a correct answer at score=9 leaves score at 9.
- REQ-029: Macro SCORE_SATURATE_EN undefined: a correct answer at score=9 wraps score to 0.

Verification (bench uses DEBOUNCE_CYCLES=4)
- REQ-030: sw=10'd37, target=10'd37, clean submit press held 10 cycles -> one result_valid pulse, correct=1, score 0->1, binary=37 frozen until release.
- REQ-031: sw=10'd500, target=10'd499, submit -> correct=0, score unchanged; change sw to 12 during WAIT_RELEASE -> binary stays 500 until IDLE, then 12.
- REQ-032: submit toggles every 2 cycles for 20 cycles then stays high -> exactly one result_valid pulse.
- REQ-033: nine correct submits then a tenth -> score=9 with SCORE_SATURATE_EN, score=0 without.
- REQ-034: score=5, clear press timed to coincide with a correct RESULT cycle -> score=0; clear alone at score=3 -> score=0.
- REQ-035: reset pulsed low during CHECK with score=4 -> all outputs 0 immediately, no result_valid after release.
